// File: rtl/aq_djpeg_dqt_parser_if.sv
// DQT parser bus: segment byte stream in, quantization-table RAM write port
// and segment status out.
interface aq_djpeg_dqt_parser_if;
    logic       Start;
    logic       DataInValid;
    logic [7:0] DataIn;
    logic       DataInReady;
    logic       DqtEnable;
    logic       DqtColor;
    logic [5:0] DqtCount;
    logic [7:0] DqtData;
    logic       Busy;
    logic       Done;
    logic       Error;

    modport master (
        output Start, DataInValid, DataIn,
        input  DataInReady, DqtEnable, DqtColor, DqtCount, DqtData, Busy, Done, Error
    );

    modport slave (
        input  Start, DataInValid, DataIn,
        output DataInReady, DqtEnable, DqtColor, DqtCount, DqtData, Busy, Done, Error
    );
endinterface

// File: rtl/aq_djpeg_dqt_parser.sv
// JPEG DQT segment parser: walks Lq / PqTq / 64-entry tables and streams
// 8-bit quantizers into the table RAM; rejects 16-bit precision and truncation.
module aq_djpeg_dqt_parser (
    input logic                  clk,
    input logic                  rst,
    aq_djpeg_dqt_parser_if.slave dqt
);

    typedef enum logic [2:0] {
        StIdle, StLenHi, StLenLo, StPqTq, StTable, StSkip, StDone, StErr
    } stateE;

    stateE       stateQ, stateD;
    logic [7:0]  lenHiQ, lenHiD;
    logic [15:0] remQ, remD;
    logic [5:0]  idxQ, idxD;
    logic [3:0]  tqQ, tqD;
    logic [15:0] lenFull;
    logic        accept, wrEn;

    logic       readyQ, busyQ, doneQ, errorQ, enQ, colorQ;
    logic [5:0] countQ;
    logic [7:0] dataQ;

    assign accept  = readyQ & dqt.DataInValid;
    assign lenFull = {lenHiQ, dqt.DataIn};

    always_comb begin
        stateD = stateQ;
        lenHiD = lenHiQ;
        remD   = remQ;
        idxD   = idxQ;
        tqD    = tqQ;
        wrEn   = 1'b0;
        unique case (stateQ)
            StIdle: if (dqt.Start) stateD = StLenHi;
            StLenHi: if (accept) begin
                lenHiD = dqt.DataIn;
                stateD = StLenLo;
            end
            StLenLo: if (accept) begin
                if (lenFull < 16'd2) begin
                    remD   = '0;
                    stateD = StErr;
                end else begin
                    remD   = lenFull - 16'd2;
                    stateD = (lenFull == 16'd2) ? StDone : StPqTq;
                end
            end
            StPqTq: if (accept) begin
                remD = remQ - 16'd1;
                tqD  = dqt.DataIn[3:0];
                idxD = '0;
                if (dqt.DataIn[7:4] != 4'd0) stateD = StSkip;
                // An 8-bit table header with no bytes left behind it is a truncated table.
                else if (remQ == 16'd1)      stateD = StErr;
                else                         stateD = StTable;
            end
            StTable: if (accept) begin
                remD = remQ - 16'd1;
                idxD = idxQ + 6'd1;
                wrEn = (tqQ < 4'd2);
                if (idxQ == 6'd63)      stateD = (remQ == 16'd1) ? StDone : StPqTq;
                else if (remQ == 16'd1) stateD = StErr;
            end
            StSkip: begin
                if (remQ == 16'd0) begin
                    stateD = StErr;
                end else if (accept) begin
                    remD = remQ - 16'd1;
                    if (remQ == 16'd1) stateD = StErr;
                end
            end
            StDone:  stateD = StIdle;
            StErr:   stateD = StIdle;
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateQ <= StIdle;
            lenHiQ <= '0;
            remQ   <= '0;
            idxQ   <= '0;
            tqQ    <= '0;
        end else begin
            stateQ <= stateD;
            lenHiQ <= lenHiD;
            remQ   <= remD;
            idxQ   <= idxD;
            tqQ    <= tqD;
        end
    end

    // Status flags are decoded from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            readyQ <= 1'b0;
            busyQ  <= 1'b0;
            doneQ  <= 1'b0;
            errorQ <= 1'b0;
            enQ    <= 1'b0;
            colorQ <= 1'b0;
            countQ <= '0;
            dataQ  <= '0;
        end else begin
            readyQ <= stateD inside {StLenHi, StLenLo, StPqTq, StTable, StSkip};
            busyQ  <= (stateD != StIdle);
            doneQ  <= (stateD == StDone);
            errorQ <= (stateD == StErr);
            enQ    <= wrEn;
            if (wrEn) begin
                colorQ <= tqQ[0];
                countQ <= idxQ;
                dataQ  <= dqt.DataIn;
            end
        end
    end

    assign dqt.DataInReady = readyQ;
    assign dqt.Busy        = busyQ;
    assign dqt.Done        = doneQ;
    assign dqt.Error       = errorQ;
    assign dqt.DqtEnable   = enQ;
    assign dqt.DqtColor    = colorQ;
    assign dqt.DqtCount    = countQ;
    assign dqt.DqtData     = dataQ;

endmodule
